// File: rtl/memory_access_pkg.sv
// Shared types for the MEM stage: opcodes, pipeline records, access sizes and FSM encodings.
package memory_access_pkg;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;
  localparam int CNT_W  = 32;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_BEQ,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } op_t;

  typedef enum logic [2:0] {SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_D = 3'd3} mem_size_t;

  typedef logic [1:0] mstate_t;
  localparam mstate_t ST_IDLE = 2'd0;
  localparam mstate_t ST_BUSY = 2'd1;
  localparam mstate_t ST_DONE = 2'd2;

  typedef struct packed {
    logic            we;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
  } csr_req_t;

  typedef struct packed {
    logic [31:0]      inst;
    logic [XLEN-1:0]  inst_pc;
    op_t              op;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  write_mem_data;
    logic             valid;
    logic [CNT_W-1:0] inst_counter;
    csr_req_t         csr;
    logic             jump;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0]      inst;
    logic [XLEN-1:0]  inst_pc;
    op_t              op;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  reg_write_data;
    logic             valid;
    logic [CNT_W-1:0] inst_counter;
    csr_req_t         csr;
    logic             jump;
    logic             misaligned;
  } mem_wb_t;

  typedef struct packed {
    logic            reg_write_enable;
    logic [4:0]      reg_dest_addr;
    logic [XLEN-1:0] reg_write_data;
  } reg_writer_t;

  function automatic logic is_load(op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_store(op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic is_mem(op_t op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_unsigned_load(op_t op);
    return op inside {OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_arith(op_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL};
  endfunction

  function automatic mem_size_t mem_size(op_t op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      OP_LW, OP_LWU, OP_SW: return SZ_W;
      OP_LD, OP_SD:         return SZ_D;
      default:              return SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// Byte-lane steering for the data bus: size/strobe/store lanes, load extraction and alignment check.
module memory_access_mem_align
  import memory_access_pkg::*;
(
  input  op_t             op_i,
  input  logic [2:0]      addr_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] rd_word_i,
  output logic [2:0]      size_o,
  output logic [7:0]      strobe_o,
  output logic [XLEN-1:0] lane_data_o,
  output logic [XLEN-1:0] load_val_o,
  output logic            misaligned_o
);

  mem_size_t       sz;
  logic [5:0]      shamt;
  logic [2:0]      mask;
  logic            uns;
  logic [XLEN-1:0] rd_shifted;

  always_comb begin
    sz          = mem_size(op_i);
    uns         = is_unsigned_load(op_i);
    shamt       = {addr_i, 3'b000};
    rd_shifted  = rd_word_i >> shamt;
    size_o      = sz;
    lane_data_o = st_data_i << shamt;
    mask        = 3'd7;
    strobe_o    = 8'hFF;
    load_val_o  = rd_shifted;
    case (sz)
      SZ_B: begin
        mask       = 3'd0;
        strobe_o   = 8'h01 << addr_i;
        load_val_o = {{(XLEN-8){rd_shifted[7] & ~uns}}, rd_shifted[7:0]};
      end
      SZ_H: begin
        mask       = 3'd1;
        strobe_o   = 8'h03 << addr_i;
        load_val_o = {{(XLEN-16){rd_shifted[15] & ~uns}}, rd_shifted[15:0]};
      end
      SZ_W: begin
        mask       = 3'd3;
        strobe_o   = 8'h0F << addr_i;
        load_val_o = {{(XLEN-32){rd_shifted[31] & ~uns}}, rd_shifted[31:0]};
      end
      default: ;
    endcase
    if (!is_store(op_i)) strobe_o = 8'h00;
    misaligned_o = is_mem(op_i) && ((addr_i & mask) != 3'd0);
  end

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: issues data-bus accesses, stalls via ok, builds mem_wb and the MEM forward.
module memory_access
  import memory_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  ex_mem_t           ex_mem_state,
  output mem_wb_t           mem_wb_state,
  output reg_writer_t       forward,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              misaligned,
  output logic              ok
);

  mstate_t          state_q, state_d;
  logic [CNT_W-1:0] last_cnt_q, last_cnt_d;
  logic [XLEN-1:0]  data_q, data_d;

  logic            mem_op, is_new, mis, issue, complete, have_data, align_mis;
  logic [XLEN-1:0] rd_word, load_val, rwd;

  memory_access_mem_align u_align (
    .op_i         (ex_mem_state.op),
    .addr_i       (ex_mem_state.alu_result[2:0]),
    .st_data_i    (ex_mem_state.write_mem_data),
    .rd_word_i    (rd_word),
    .size_o       (dreq_size),
    .strobe_o     (dreq_strobe),
    .lane_data_o  (dreq_data),
    .load_val_o   (load_val),
    .misaligned_o (align_mis)
  );

  // A mem op counts as new until its counter has been recorded in last_cnt.
  always_comb begin
    mem_op    = ex_mem_state.valid && is_mem(ex_mem_state.op);
    is_new    = mem_op && (ex_mem_state.inst_counter != last_cnt_q);
    mis       = mem_op && align_mis;
    issue     = is_new && !mis;
    complete  = issue && dresp_data_ok;
    have_data = complete || (mem_op && !is_new && state_q == ST_DONE);
    rd_word   = complete ? dresp_data : data_q;
  end

  always_comb begin
    state_d    = state_q;
    last_cnt_d = last_cnt_q;
    data_d     = data_q;
    if (is_new && mis) begin
      state_d    = ST_DONE;
      last_cnt_d = ex_mem_state.inst_counter;
      data_d     = '0;
    end else if (complete) begin
      state_d    = ST_DONE;
      last_cnt_d = ex_mem_state.inst_counter;
      data_d     = dresp_data;
    end else if (issue) begin
      state_d = ST_BUSY;
    end else if (state_q == ST_BUSY) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_cnt_q <= '1;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_cnt_q <= last_cnt_d;
      data_q     <= data_d;
    end
  end

  // Outputs are gated by rst_n so the bus request drops the moment reset asserts.
  always_comb begin
    if (mis)                                   rwd = '0;
    else if (mem_op && is_load(ex_mem_state.op)) rwd = load_val;
    else                                       rwd = ex_mem_state.alu_result;

    dreq_valid = rst_n && issue;
    dreq_addr  = ex_mem_state.alu_result;
    ok         = !rst_n || !issue || dresp_data_ok;
    misaligned = rst_n && mis;

    mem_wb_state.inst           = ex_mem_state.inst;
    mem_wb_state.inst_pc        = ex_mem_state.inst_pc;
    mem_wb_state.op             = ex_mem_state.op;
    mem_wb_state.alu_result     = ex_mem_state.alu_result;
    mem_wb_state.reg_write_data = rwd;
    mem_wb_state.valid          = ex_mem_state.valid;
    mem_wb_state.inst_counter   = ex_mem_state.inst_counter;
    mem_wb_state.csr            = ex_mem_state.csr;
    mem_wb_state.jump           = ex_mem_state.jump;
    mem_wb_state.misaligned     = mis;

    forward.reg_write_enable = rst_n && (mem_op
        ? (is_load(ex_mem_state.op) && have_data && !mis)
        : (ex_mem_state.valid && is_arith(ex_mem_state.op)));
    forward.reg_dest_addr    = ex_mem_state.inst[11:7];
    forward.reg_write_data   = rwd;
  end

endmodule
